sw_code_debounce: RTL

Conditions the three raw slide-switch inputs into a clean, glitch-free 3-bit code for the 3-to-8 LED decoder stage directly downstream. Each switch bit passes through a two-flop synchronizer, then a shared stability counter. The held code updates only after the whole 3-bit word has stayed constant for a programmable number of cycles. A one-cycle change strobe accompanies every update; an optional auto-scan mode steps the code 0→7 for an LED running-light demo.

---
 rtl/sw_code_debounce.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sw_code_debounce.sv
// Slide-switch conditioner: 2-flop synchronizer, shared stability counter, registered code + change strobe.
// Optional LED running-light scan mode is compiled in when the SW_SCAN_EN macro is defined.
module sw_code_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned SCAN_DIV   = 25_000_000
) (
  input  logic       Clk_In,
  input  logic       Rst_n_In,
  input  logic [2:0] Sw_In,
`ifdef SW_SCAN_EN
  input  logic       Mode_In,
`endif
  output logic [2:0] Code_Out,
  output logic       Chg_Out
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || SCAN_DIV < 2) begin : g_bad_params
    $error("sw_code_debounce: DEB_CYCLES and SCAN_DIV must both be >= 2");
  end

  typedef enum logic {
    STABLE,
    SETTLE
  } state_t;

  logic [2:0]    sw_s1, sw_s2;
  state_t        state;
  logic [2:0]    cand;
  logic [CW-1:0] cnt;
  logic          accept;

  always_ff @(posedge Clk_In or negedge Rst_n_In) begin
    if (!Rst_n_In) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= Sw_In;
      sw_s2 <= sw_s1;
    end
  end

  // candidate has matched the synchronized word for the full window on this edge
  always_comb begin
    accept = (state == SETTLE) && (sw_s2 == cand) && (cnt == CNT_MAX);
  end

`ifdef SW_SCAN_EN
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic          mode_s1, mode_s2, mode_q;
  logic [DW-1:0] div;
  logic [2:0]    deb;
  logic [2:0]    deb_nxt;
  logic          mode_exit;
  logic          scan_step;

  always_ff @(posedge Clk_In or negedge Rst_n_In) begin
    if (!Rst_n_In) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_q  <= 1'b0;
      div     <= '0;
    end else begin
      mode_s1 <= Mode_In;
      mode_s2 <= mode_s1;
      mode_q  <= mode_s2;
      if (!mode_s2 || div == DIV_MAX) div <= '0;
      else                            div <= div + 1'b1;
    end
  end

  // the debouncer keeps tracking during scan; deb holds its latest accepted word for scan exit
  always_comb begin
    deb_nxt   = accept ? cand : deb;
    mode_exit = !mode_s2 && mode_q;
    scan_step = mode_s2 && (div == DIV_MAX);
  end
`endif

  always_ff @(posedge Clk_In or negedge Rst_n_In) begin
    if (!Rst_n_In) begin
      state    <= STABLE;
      cand     <= '0;
      cnt      <= CNT_MAX;
      Code_Out <= '0;
      Chg_Out  <= 1'b0;
`ifdef SW_SCAN_EN
      deb      <= '0;
`endif
    end else begin
      Chg_Out <= 1'b0;
      case (state)
        STABLE: begin
          if (sw_s2 != cand) begin
            cand  <= sw_s2;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sw_s2 != cand) begin
            cand <= sw_s2;
            cnt  <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            state <= STABLE;
          end
        end
        default: state <= STABLE;
      endcase
`ifdef SW_SCAN_EN
      deb <= deb_nxt;
      if (mode_exit) begin
        Code_Out <= deb_nxt;
        Chg_Out  <= (deb_nxt != Code_Out);
      end else if (mode_s2) begin
        if (scan_step) begin
          Code_Out <= Code_Out + 3'd1;
          Chg_Out  <= 1'b1;
        end
      end else if (accept && cand != Code_Out) begin
        Code_Out <= cand;
        Chg_Out  <= 1'b1;
      end
`else
      if (accept && cand != Code_Out) begin
        Code_Out <= cand;
        Chg_Out  <= 1'b1;
      end
`endif
    end
  end

endmodule
